spi_mitm_rule_engine: RTL and testbench

//  Parametrised successor of the SPI MITM decision logic. Sits between the bus sniffers and the

---
 rtl/spi_mitm_rule_engine_if.sv | 48 ++++
 rtl/spi_mitm_rule_engine.sv | 197 +++++++++++++++++++
 tb/tb_spi_mitm_rule_engine.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_mitm_rule_engine_if.sv
// rtl/spi_mitm_rule_engine_if.sv - sniffer/injector/rule-programming bundle for the MITM rule engine
interface spi_mitm_rule_engine_if #(
    parameter int MAX_DATA_SIZE = 16,
    parameter int CMD_BITS      = 3,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_RULES     = 4,
    parameter int MAX_BURST     = 4
);
    localparam int DSW = $clog2(MAX_DATA_SIZE + 1);
    localparam int RIW = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;
    localparam int BLW = $clog2(MAX_BURST + 1);

    logic                     mitm_start;
    logic [BLW-1:0]           burst_len;
    logic                     eval;
    logic [MAX_DATA_SIZE-1:0] real_miso_data;
    logic [MAX_DATA_SIZE-1:0] real_mosi_data;
    logic                     rule_wr_en;
    logic [RIW-1:0]           rule_idx;
    logic [CMD_BITS-1:0]      rule_cmd;
    logic [ADDR_BITS-1:0]     rule_addr;
    logic [ADDR_BITS-1:0]     rule_addr_mask;
    logic [1:0]               rule_mode;
    logic [DATA_BITS-1:0]     rule_value;
    logic [MAX_DATA_SIZE-1:0] fake_miso_data;
    logic [MAX_DATA_SIZE-1:0] fake_mosi_data;
    logic [DSW-1:0]           data_size;
    logic                     fake_miso_select;
    logic                     fake_mosi_select;
    logic                     eval_done;
    logic                     mitm_done;
    logic [7:0]               hit_count;

    modport master (
        output mitm_start, burst_len, eval, real_miso_data, real_mosi_data,
               rule_wr_en, rule_idx, rule_cmd, rule_addr, rule_addr_mask, rule_mode, rule_value,
        input  fake_miso_data, fake_mosi_data, data_size, fake_miso_select, fake_mosi_select,
               eval_done, mitm_done, hit_count
    );

    modport slave (
        input  mitm_start, burst_len, eval, real_miso_data, real_mosi_data,
               rule_wr_en, rule_idx, rule_cmd, rule_addr, rule_addr_mask, rule_mode, rule_value,
        output fake_miso_data, fake_mosi_data, data_size, fake_miso_select, fake_mosi_select,
               eval_done, mitm_done, hit_count
    );
endinterface

// File: rtl/spi_mitm_rule_engine.sv
// rtl/spi_mitm_rule_engine.sv - SPI MITM transaction stepper with programmable match/replace rule table
module spi_mitm_rule_engine #(
    parameter int MAX_DATA_SIZE = 16,
    parameter int CMD_BITS      = 3,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_RULES     = 4,
    parameter int MAX_BURST     = 4
) (
    input logic                   sys_clk,
    input logic                   rst,
    spi_mitm_rule_engine_if.slave bus
);
    localparam int DSW = $clog2(MAX_DATA_SIZE + 1);
    localparam int BLW = $clog2(MAX_BURST + 1);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_CMD, S_ADDR, S_DATA, S_DONE} state_t;

    state_t state_q, state_d;

    // stage_q: 0 = ready, 1/2 = evaluation in flight; results land when it reaches 2
    logic [1:0]               stage_q;
    logic                     eval_done_q;
    logic [BLW-1:0]           eff_len_q, eff_len_d, word_cnt_q, word_nxt;
    logic [CMD_BITS-1:0]      cmd_q;
    logic                     hit_q;
    logic [1:0]               hit_mode_q;
    logic [DATA_BITS-1:0]     hit_value_q;
    logic [MAX_DATA_SIZE-1:0] fake_miso_q;
    logic                     miso_sel_q;
    logic [DSW-1:0]           data_size_q;
    logic [7:0]               hit_count_q;

    logic [CMD_BITS-1:0]  r_cmd   [NUM_RULES];
    logic [ADDR_BITS-1:0] r_addr  [NUM_RULES];
    logic [ADDR_BITS-1:0] r_mask  [NUM_RULES];
    logic [1:0]           r_mode  [NUM_RULES];
    logic [DATA_BITS-1:0] r_value [NUM_RULES];

    logic                 accept, apply, last_word;
    logic [ADDR_BITS-1:0] lk_addr;
    logic                 lk_hit;
    logic [1:0]           lk_mode;
    logic [DATA_BITS-1:0] lk_value;
    logic                 unused_bits;

    assign accept    = bus.eval && eval_done_q &&
                       (state_q inside {S_ARM, S_CMD, S_ADDR, S_DATA});
    assign apply     = (stage_q == 2'd2);
    assign word_nxt  = word_cnt_q + 1'b1;
    assign last_word = (word_nxt == eff_len_q);
    assign lk_addr   = bus.real_mosi_data[ADDR_BITS-1:0];
    assign unused_bits = ^{bus.real_miso_data, bus.real_mosi_data[MAX_DATA_SIZE-1:ADDR_BITS]};

    // Fake MISO word for a given index, zero when the latched hit does not inject
    function automatic logic [MAX_DATA_SIZE-1:0] word_data(input logic [BLW-1:0] w);
        logic [DATA_BITS-1:0] v;
        v = hit_value_q + (hit_mode_q[0] ? DATA_BITS'(w) : '0);
        return (hit_q && hit_mode_q[1]) ? MAX_DATA_SIZE'(v) : '0;
    endfunction

    // Effective word count: 0 means one word, anything above MAX_BURST clamps
    always_comb begin
        eff_len_d = bus.burst_len;
        if (bus.burst_len == '0)
            eff_len_d = BLW'(1);
        else if (bus.burst_len > BLW'(MAX_BURST))
            eff_len_d = BLW'(MAX_BURST);
    end

    // Rule lookup on the live address; descending scan so the lowest matching slot wins
    always_comb begin
        lk_hit   = 1'b0;
        lk_mode  = 2'b00;
        lk_value = '0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (r_mode[i] != 2'b00 && cmd_q == r_cmd[i] &&
                ((lk_addr ^ r_addr[i]) & r_mask[i]) == '0) begin
                lk_hit   = 1'b1;
                lk_mode  = r_mode[i];
                lk_value = r_value[i];
            end
        end
    end

    // Next-state logic: phase advances when an evaluation's results land
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.mitm_start) state_d = S_ARM;
            S_ARM:   if (apply) state_d = S_CMD;
            S_CMD:   if (apply) state_d = S_ADDR;
            S_ADDR:  if (apply) state_d = S_DATA;
            S_DATA:  if (apply && last_word) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Rule table writes; out-of-range slots are dropped
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_RULES; i++) begin
                r_cmd[i]   <= '0;
                r_addr[i]  <= '0;
                r_mask[i]  <= '0;
                r_mode[i]  <= 2'b00;
                r_value[i] <= '0;
            end
        end else if (bus.rule_wr_en && int'(bus.rule_idx) < NUM_RULES) begin
            r_cmd[bus.rule_idx]   <= bus.rule_cmd;
            r_addr[bus.rule_idx]  <= bus.rule_addr;
            r_mask[bus.rule_idx]  <= bus.rule_addr_mask;
            r_mode[bus.rule_idx]  <= bus.rule_mode;
            r_value[bus.rule_idx] <= bus.rule_value;
        end
    end

    // Handshake pipeline: capture fields on accept, publish outputs two cycles later
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            stage_q     <= 2'd0;
            eval_done_q <= 1'b1;
            eff_len_q   <= BLW'(1);
            word_cnt_q  <= '0;
            cmd_q       <= '0;
            hit_q       <= 1'b0;
            hit_mode_q  <= 2'b00;
            hit_value_q <= '0;
            fake_miso_q <= '0;
            miso_sel_q  <= 1'b0;
            data_size_q <= '0;
            hit_count_q <= 8'd0;
        end else begin
            if (state_q == S_IDLE && bus.mitm_start)
                eff_len_q <= eff_len_d;
            if (accept) begin
                eval_done_q <= 1'b0;
                stage_q     <= 2'd1;
                if (state_q == S_CMD)
                    cmd_q <= bus.real_mosi_data[CMD_BITS-1:0];
                if (state_q == S_ADDR) begin
                    hit_q       <= lk_hit;
                    hit_mode_q  <= lk_mode;
                    hit_value_q <= lk_value;
                    if (lk_hit && hit_count_q != 8'hFF)
                        hit_count_q <= hit_count_q + 8'd1;
                end
            end else if (stage_q == 2'd1) begin
                stage_q <= 2'd2;
            end else if (apply) begin
                stage_q     <= 2'd0;
                eval_done_q <= 1'b1;
                case (state_q)
                    S_ARM: begin
                        data_size_q <= DSW'(CMD_BITS);
                        fake_miso_q <= '0;
                        miso_sel_q  <= 1'b0;
                    end
                    S_CMD: data_size_q <= DSW'(ADDR_BITS);
                    S_ADDR: begin
                        data_size_q <= DSW'(DATA_BITS);
                        word_cnt_q  <= '0;
                        fake_miso_q <= word_data('0);
                        miso_sel_q  <= hit_q && hit_mode_q[1];
                    end
                    S_DATA: begin
                        word_cnt_q <= word_nxt;
                        if (last_word) begin
                            data_size_q <= '0;
                            fake_miso_q <= '0;
                            miso_sel_q  <= 1'b0;
                        end else begin
                            fake_miso_q <= word_data(word_nxt);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.fake_miso_data   = fake_miso_q;
    assign bus.fake_mosi_data   = '0;
    assign bus.data_size        = data_size_q;
    assign bus.fake_miso_select = miso_sel_q;
    assign bus.fake_mosi_select = 1'b0;
    assign bus.eval_done        = eval_done_q;
    assign bus.mitm_done        = (state_q == S_DONE);
    assign bus.hit_count        = hit_count_q;
endmodule

// File: tb/tb_spi_mitm_rule_engine.sv
// tb/tb_spi_mitm_rule_engine.sv - directed self-checking bench for spi_mitm_rule_engine
module tb_spi_mitm_rule_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   lat;

    always #5 clk = ~clk;

    spi_mitm_rule_engine_if bus();

    spi_mitm_rule_engine dut (
        .sys_clk(clk),
        .rst    (rst_n),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_rule(input logic [1:0] idx, input logic [2:0] c, input logic [7:0] a,
                           input logic [7:0] m, input logic [1:0] md, input logic [7:0] v);
        bus.rule_wr_en = 1'b1; bus.rule_idx = idx; bus.rule_cmd = c; bus.rule_addr = a;
        bus.rule_addr_mask = m; bus.rule_mode = md; bus.rule_value = v;
        tick();
        bus.rule_wr_en = 1'b0;
    endtask

    task automatic start_txn(input logic [2:0] bl);
        bus.mitm_start = 1'b1; bus.burst_len = bl;
        tick();
        bus.mitm_start = 1'b0;
    endtask

    // One accepted eval, then wait (bounded) for eval_done; lat = cycles after the sampling edge
    task automatic send_eval(input logic [15:0] mosi, output int l);
        bus.eval = 1'b1; bus.real_mosi_data = mosi;
        tick();
        bus.eval = 1'b0;
        l = 0;
        while (bus.eval_done !== 1'b1 && l < 20) begin
            tick();
            l++;
        end
    endtask

    task automatic head(input logic [2:0] bl, input logic [15:0] c, input logic [15:0] a);
        int l;
        start_txn(bl);
        send_eval(16'h0000, l);
        send_eval(c, l);
        send_eval(a, l);
    endtask

    task automatic test_reset();
        tick(); tick();
        total++; if (bus.eval_done !== 1'b1) begin bad++; $display("FAIL rst_eval_done got %b want 1", bus.eval_done); end
        total++; if (bus.mitm_done !== 1'b0) begin bad++; $display("FAIL rst_mitm_done got %b want 0", bus.mitm_done); end
        total++; if (bus.data_size !== 5'd0) begin bad++; $display("FAIL rst_data_size got %0d want 0", bus.data_size); end
        total++; if (bus.fake_miso_data !== 16'h0 || bus.fake_mosi_data !== 16'h0) begin bad++; $display("FAIL rst_fake got %h/%h want 0/0", bus.fake_miso_data, bus.fake_mosi_data); end
        total++; if (bus.fake_miso_select !== 1'b0 || bus.fake_mosi_select !== 1'b0) begin bad++; $display("FAIL rst_select got %b%b want 00", bus.fake_miso_select, bus.fake_mosi_select); end
        total++; if (bus.hit_count !== 8'd0) begin bad++; $display("FAIL rst_hit_count got %0d want 0", bus.hit_count); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_replace();
        wr_rule(2'd0, 3'b110, 8'hA2, 8'hFF, 2'b10, 8'h5A);
        start_txn(3'd1);
        send_eval(16'h0000, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL rep_latency got %0d want 2", lat); end
        total++; if (bus.data_size !== 5'd3) begin bad++; $display("FAIL rep_size_cmd got %0d want 3", bus.data_size); end
        send_eval(16'h0006, lat);
        total++; if (bus.data_size !== 5'd8) begin bad++; $display("FAIL rep_size_addr got %0d want 8", bus.data_size); end
        send_eval(16'h00A2, lat);
        total++; if (bus.fake_miso_data !== 16'h005A) begin bad++; $display("FAIL rep_fake got %h want 005a", bus.fake_miso_data); end
        total++; if (bus.fake_miso_select !== 1'b1) begin bad++; $display("FAIL rep_sel got %b want 1", bus.fake_miso_select); end
        total++; if (bus.data_size !== 5'd8) begin bad++; $display("FAIL rep_size_data got %0d want 8", bus.data_size); end
        total++; if (bus.hit_count !== 8'd1) begin bad++; $display("FAIL rep_hits got %0d want 1", bus.hit_count); end
        send_eval(16'h0000, lat);
        total++; if (bus.mitm_done !== 1'b1) begin bad++; $display("FAIL rep_done got %b want 1", bus.mitm_done); end
        total++; if (bus.data_size !== 5'd0 || bus.fake_miso_select !== 1'b0) begin bad++; $display("FAIL rep_end_outputs got size=%0d sel=%b want 0/0", bus.data_size, bus.fake_miso_select); end
        tick();
        total++; if (bus.mitm_done !== 1'b0) begin bad++; $display("FAIL rep_done_pulse got %b want 0", bus.mitm_done); end
    endtask

    task automatic test_miss();
        head(3'd1, 16'h0006, 16'h00A3);
        total++; if (bus.fake_miso_select !== 1'b0 || bus.fake_miso_data !== 16'h0) begin bad++; $display("FAIL miss_out got sel=%b data=%h want 0/0000", bus.fake_miso_select, bus.fake_miso_data); end
        total++; if (bus.hit_count !== 8'd1) begin bad++; $display("FAIL miss_hits got %0d want 1", bus.hit_count); end
        send_eval(16'h0000, lat);
        total++; if (bus.mitm_done !== 1'b1) begin bad++; $display("FAIL miss_done got %b want 1", bus.mitm_done); end
        tick();
    endtask

    task automatic test_priority();
        logic [15:0] addrs [3];
        logic [15:0] exp_d [3];
        logic        exp_s [3];
        addrs = '{16'h00A2, 16'h00A7, 16'h00B2};
        exp_d = '{16'h0022, 16'h0011, 16'h0000};
        exp_s = '{1'b1, 1'b1, 1'b0};
        wr_rule(2'd0, 3'b110, 8'hA2, 8'hFF, 2'b10, 8'h22);
        wr_rule(2'd1, 3'b110, 8'hA0, 8'hF0, 2'b10, 8'h11);
        for (int i = 0; i < 3; i++) begin
            head(3'd1, 16'h0006, addrs[i]);
            total++; if (bus.fake_miso_data !== exp_d[i] || bus.fake_miso_select !== exp_s[i]) begin bad++; $display("FAIL prio_%0d got %h/%b want %h/%b", i, bus.fake_miso_data, bus.fake_miso_select, exp_d[i], exp_s[i]); end
            send_eval(16'h0000, lat);
            total++; if (bus.mitm_done !== 1'b1) begin bad++; $display("FAIL prio_done_%0d got %b want 1", i, bus.mitm_done); end
            tick();
        end
        total++; if (bus.hit_count !== 8'd3) begin bad++; $display("FAIL prio_hits got %0d want 3", bus.hit_count); end
    endtask

    task automatic test_burst();
        logic [2:0] bls [3];
        int         nw  [3];
        logic [7:0] e;
        bls = '{3'd3, 3'd0, 3'd7};
        nw  = '{3, 1, 4};
        wr_rule(2'd0, 3'b110, 8'hFE, 8'hFF, 2'b11, 8'hFE);
        for (int t = 0; t < 3; t++) begin
            head(bls[t], 16'h0006, 16'h00FE);
            for (int w = 0; w < nw[t]; w++) begin
                e = 8'hFE + 8'(w);
                total++; if (bus.fake_miso_data !== {8'h00, e} || bus.mitm_done !== 1'b0) begin bad++; $display("FAIL burst_%0d_w%0d got %h done=%b want %h done=0", t, w, bus.fake_miso_data, bus.mitm_done, e); end
                send_eval(16'h0000, lat);
            end
            total++; if (bus.mitm_done !== 1'b1) begin bad++; $display("FAIL burst_done_%0d got %b want 1", t, bus.mitm_done); end
            tick();
        end
        total++; if (bus.hit_count !== 8'd6) begin bad++; $display("FAIL burst_hits got %0d want 6", bus.hit_count); end
    endtask

    task automatic test_ignore();
        start_txn(3'd1);
        send_eval(16'h0000, lat);
        bus.eval = 1'b1; bus.real_mosi_data = 16'h0006; bus.mitm_start = 1'b1; bus.burst_len = 3'd3;
        tick();
        total++; if (bus.eval_done !== 1'b0) begin bad++; $display("FAIL ign_busy got %b want 0", bus.eval_done); end
        bus.real_mosi_data = 16'h0005;
        tick();
        bus.eval = 1'b0; bus.mitm_start = 1'b0;
        total++; if (bus.eval_done !== 1'b0) begin bad++; $display("FAIL ign_busy2 got %b want 0", bus.eval_done); end
        tick();
        total++; if (bus.eval_done !== 1'b1 || bus.data_size !== 5'd8) begin bad++; $display("FAIL ign_ready got %b size=%0d want 1/8", bus.eval_done, bus.data_size); end
        send_eval(16'h00FE, lat);
        total++; if (bus.fake_miso_data !== 16'h00FE || bus.fake_miso_select !== 1'b1) begin bad++; $display("FAIL ign_fake got %h/%b want 00fe/1", bus.fake_miso_data, bus.fake_miso_select); end
        send_eval(16'h0000, lat);
        total++; if (bus.mitm_done !== 1'b1) begin bad++; $display("FAIL ign_done got %b want 1", bus.mitm_done); end
        tick();
        bus.eval = 1'b1;
        tick(); tick();
        bus.eval = 1'b0;
        total++; if (bus.eval_done !== 1'b1 || bus.data_size !== 5'd0) begin bad++; $display("FAIL ign_idle got %b size=%0d want 1/0", bus.eval_done, bus.data_size); end
        total++; if (bus.hit_count !== 8'd7) begin bad++; $display("FAIL ign_hits got %0d want 7", bus.hit_count); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        wr_rule(2'd0, 3'b110, 8'hA2, 8'hFF, 2'b10, 8'h5A);
        head(3'd1, 16'h0006, 16'h00A2);
        total++; if (bus.fake_miso_select !== 1'b1) begin bad++; $display("FAIL rm_pre_sel got %b want 1", bus.fake_miso_select); end
        bus.eval = 1'b1; bus.real_mosi_data = 16'h0000;
        tick();
        bus.eval = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (bus.eval_done !== 1'b1 || bus.fake_miso_select !== 1'b0 || bus.fake_miso_data !== 16'h0 || bus.data_size !== 5'd0 || bus.hit_count !== 8'd0) begin bad++; $display("FAIL rm_async got ed=%b sel=%b d=%h sz=%0d hc=%0d want 1/0/0000/0/0", bus.eval_done, bus.fake_miso_select, bus.fake_miso_data, bus.data_size, bus.hit_count); end
        for (int i = 0; i < 4; i++) begin
            if (bus.mitm_done !== 1'b0) seen++;
            tick();
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rm_no_done got %0d pulses want 0", seen); end
        rst_n = 1'b1;
        tick();
        head(3'd1, 16'h0006, 16'h00A2);
        total++; if (bus.fake_miso_select !== 1'b0 || bus.fake_miso_data !== 16'h0 || bus.hit_count !== 8'd0) begin bad++; $display("FAIL rm_rerun got sel=%b d=%h hc=%0d want 0/0000/0", bus.fake_miso_select, bus.fake_miso_data, bus.hit_count); end
        send_eval(16'h0000, lat);
        total++; if (bus.mitm_done !== 1'b1) begin bad++; $display("FAIL rm_done got %b want 1", bus.mitm_done); end
        tick();
    endtask

    initial begin
        bus.mitm_start = 1'b0; bus.burst_len = 3'd0; bus.eval = 1'b0;
        bus.real_miso_data = 16'h0; bus.real_mosi_data = 16'h0;
        bus.rule_wr_en = 1'b0; bus.rule_idx = 2'd0; bus.rule_cmd = 3'd0;
        bus.rule_addr = 8'h0; bus.rule_addr_mask = 8'h0; bus.rule_mode = 2'b00; bus.rule_value = 8'h0;
        test_reset();
        test_replace();
        test_miss();
        test_priority();
        test_burst();
        test_ignore();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
